i2s_transmitter: RTL and testbench

- Serialises processed stereo samples from the effect chain (distortion and later stages) onto an I2S link to the codec DAC.
- Generates BCLK and LRCLK as link master.
- Buffers one stereo pair with a valid/ready handshake so effect modules can present samples at any time within a frame.
- Sits at the output end of the audio path; it is the counterpart of the codec receiver that feeds the chain.

---
 rtl/audio_pkg.sv | 15 +
 rtl/i2s_transmitter_if.sv | 26 ++
 rtl/i2s_transmitter_bclk_gen.sv | 36 +++
 rtl/i2s_transmitter.sv | 107 ++++++++++
 tb/tb_i2s_transmitter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types and I2S link defaults.
// Imported by the transmitter and its bench.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  localparam int DEFAULT_SLOT_WIDTH = 32;
  localparam int DEFAULT_BCLK_DIV   = 4;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Stereo sample handshake from the effect chain
// into the I2S transmitter holding register.
interface i2s_transmitter_if #(
  parameter int SAMPLE_WIDTH = 16
);

  logic signed [SAMPLE_WIDTH-1:0] leftSampleIn;
  logic signed [SAMPLE_WIDTH-1:0] rightSampleIn;
  logic                           sampleValid;
  logic                           sampleReady;

  modport master (
    output leftSampleIn,
    output rightSampleIn,
    output sampleValid,
    input  sampleReady
  );

  modport slave (
    input  leftSampleIn,
    input  rightSampleIn,
    input  sampleValid,
    output sampleReady
  );

endinterface

// File: rtl/i2s_transmitter_bclk_gen.sv
// BCLK divider: toggles bclk every BCLK_DIV clks and
// flags the clk in which each rising/falling toggle lands.
module bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic bclkRise,
  output logic bclkFall
);

  localparam int CW =
    (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc       = (cnt == LAST);
  assign bclkRise = tc & ~bclk;
  assign bclkFall = tc & bclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (tc) begin
      cnt  <= '0;
      bclk <= ~bclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S link master: one-pair holding register feeding a
// per-frame shadow, serialised MSB first on BCLK falls.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = DEFAULT_SLOT_WIDTH,
  parameter int BCLK_DIV     = DEFAULT_BCLK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  i2s_transmitter_if.slave  smp,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underflow
);

  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int BW    = $clog2(FRAME);
  localparam int SW    = SAMPLE_WIDTH;

  localparam logic [BW-1:0] B_LAST = BW'(FRAME - 1);
  localparam logic [SW-1:0] ONE    = SW'(1);

  logic          bclk_fall;
  logic [BW-1:0] b;
  logic [BW-1:0] b_nxt;
  logic          full;
  logic          frame_start;
  logic          accept;
  logic [SW-1:0] hold_l;
  logic [SW-1:0] hold_r;
  logic [SW-1:0] shift_l;
  logic [SW-1:0] shift_r;
  logic [SW-1:0] load_l;
  logic [SW-1:0] load_r;
  logic          lr_nxt;
  logic          sd_nxt;
  int            bi;

  bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .bclkRise (),
    .bclkFall (bclk_fall)
  );

  assign smp.sampleReady = ~full;

  always_comb begin
    frame_start = bclk_fall && (b == B_LAST);
    accept      = smp.sampleValid && !full;
    b_nxt       = (b == B_LAST) ? '0 : b + 1'b1;
    load_l      = shift_l;
    load_r      = shift_r;
    if (frame_start) begin
      load_l = full ? hold_l : '0;
      load_r = full ? hold_r : '0;
    end
    bi     = int'(b_nxt);
    lr_nxt = (bi >= SLOT_WIDTH - 1) &&
             (bi <= FRAME - 2);
    sd_nxt = 1'b0;
    // Bits beyond the sample inside a slot are padding.
    if (bi < SW) begin
      sd_nxt = |(load_l & (ONE << (SW - 1 - bi)));
    end else if ((bi >= SLOT_WIDTH) &&
                 (bi < SLOT_WIDTH + SW)) begin
      sd_nxt = |(load_r &
                 (ONE << (SW - 1 - (bi - SLOT_WIDTH))));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b         <= B_LAST;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      underflow <= 1'b0;
      full      <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      shift_l   <= '0;
      shift_r   <= '0;
    end else begin
      underflow <= frame_start && !full;
      if (bclk_fall) begin
        b       <= b_nxt;
        lrclk   <= lr_nxt;
        sdata   <= sd_nxt;
        shift_l <= load_l;
        shift_r <= load_r;
      end
      if (accept) begin
        hold_l <= smp.leftSampleIn;
        hold_r <= smp.rightSampleIn;
      end
      // An accept at frame start lands for the next frame.
      full <= accept | (full & ~frame_start);
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench: two transmitters (DIV 2/SLOT 32, DIV 1/SLOT 17)
// against a frame-level model plus directed sequences.
module tb_i2s_transmitter;
  import audio_pkg::*;

  typedef struct {
    int   b;
    logic sd;
    logic lr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst   [2];
  logic    drv_v [2];
  stereo_t drv_p [2];
  logic    o_bclk[2];
  logic    o_lr  [2];
  logic    o_sd  [2];
  logic    o_uf  [2];
  logic    o_rdy [2];

  int pass_cnt = 0;
  int total    = 0;

  int      n      [2];
  logic    hv     [2];
  stereo_t hp     [2];
  stereo_t cur    [2];
  logic    exp_uf [2];
  logic    acc    [2];

  i2s_transmitter_if #(.SAMPLE_WIDTH(16)) ifa ();
  i2s_transmitter_if #(.SAMPLE_WIDTH(16)) ifb ();

  assign ifa.leftSampleIn  = drv_p[0].left;
  assign ifa.rightSampleIn = drv_p[0].right;
  assign ifa.sampleValid   = drv_v[0];
  assign o_rdy[0]          = ifa.sampleReady;
  assign ifb.leftSampleIn  = drv_p[1].left;
  assign ifb.rightSampleIn = drv_p[1].right;
  assign ifb.sampleValid   = drv_v[1];
  assign o_rdy[1]          = ifb.sampleReady;

  i2s_transmitter #(
    .SAMPLE_WIDTH (16),
    .SLOT_WIDTH   (32),
    .BCLK_DIV     (2)
  ) dut_a (
    .clk       (clk),
    .reset     (rst[0]),
    .smp       (ifa),
    .bclk      (o_bclk[0]),
    .lrclk     (o_lr[0]),
    .sdata     (o_sd[0]),
    .underflow (o_uf[0])
  );

  i2s_transmitter #(
    .SAMPLE_WIDTH (16),
    .SLOT_WIDTH   (17),
    .BCLK_DIV     (1)
  ) dut_b (
    .clk       (clk),
    .reset     (rst[1]),
    .smp       (ifb),
    .bclk      (o_bclk[1]),
    .lrclk     (o_lr[1]),
    .sdata     (o_sd[1]),
    .underflow (o_uf[1])
  );

  function automatic int div_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int slot_of(int d);
    return (d == 0) ? 32 : 17;
  endfunction

  function automatic int bidx(int d);
    int f;
    int fr;
    f  = n[d] / (2 * div_of(d));
    fr = 2 * slot_of(d);
    return (f + fr - 1) % fr;
  endfunction

  function automatic int exp_bclk(int d);
    return (n[d] / div_of(d)) % 2;
  endfunction

  function automatic int exp_lr(int d);
    int b;
    b = bidx(d);
    return int'((b >= slot_of(d) - 1) &&
                (b <= 2 * slot_of(d) - 2));
  endfunction

  function automatic int exp_sd(int d);
    int      b;
    sample_t s;
    b = bidx(d);
    s = '0;
    if (b < 16) begin
      s = cur[d].left >> (15 - b);
    end else if (b >= slot_of(d) &&
                 b < slot_of(d) + 16) begin
      s = cur[d].right >> (15 - (b - slot_of(d)));
    end else begin
      return 0;
    end
    return int'(s[0]);
  endfunction

  function automatic stereo_t rand_pair();
    stereo_t p;
    p.left  = sample_t'($urandom_range(0, 65535));
    p.right = sample_t'($urandom_range(0, 65535));
    return p;
  endfunction

  task automatic chk(string nm, int d, int act, int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s dut%0d: got %0d want %0d at %0t",
                  nm, d, act, exp, $time);
  endtask

  // Frame-level model: a pair handed over waits for the
  // next frame start strictly after its acceptance.
  task automatic model_edge(int d);
    int hpd;
    int fr;
    hpd = 2 * div_of(d);
    fr  = 2 * slot_of(d);
    acc[d] = 1'b0;
    if (rst[d]) begin
      n[d]      = 0;
      hv[d]     = 1'b0;
      cur[d]    = '0;
      exp_uf[d] = 1'b0;
    end else begin
      acc[d]    = drv_v[d] && !hv[d];
      n[d]      = n[d] + 1;
      exp_uf[d] = 1'b0;
      if ((n[d] % hpd == 0) &&
          ((n[d] / hpd - 1) % fr == 0)) begin
        if (hv[d]) begin
          cur[d] = hp[d];
          hv[d]  = 1'b0;
        end else begin
          cur[d]    = '0;
          exp_uf[d] = 1'b1;
        end
      end
      if (acc[d]) begin
        hp[d] = drv_p[d];
        hv[d] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("bclk", d, int'(o_bclk[d]), exp_bclk(d));
      chk("lrclk", d, int'(o_lr[d]), exp_lr(d));
      chk("sdata", d, int'(o_sd[d]), exp_sd(d));
      chk("ready", d, int'(o_rdy[d]), int'(!hv[d]));
      chk("underflow", d, int'(o_uf[d]),
          int'(exp_uf[d]));
    end
    drv_v[1] = ($urandom_range(0, 3) != 0);
    drv_p[1] = rand_pair();
  endtask

  vec_t tbl [14];

  initial begin
    int seen_hi;
    int fall_at;
    int ufc;
    int rises;
    int drops;
    int k;
    int len;
    logic prev;

    tbl[0]  = '{0,  1'b1, 1'b0};
    tbl[1]  = '{1,  1'b0, 1'b0};
    tbl[2]  = '{14, 1'b0, 1'b0};
    tbl[3]  = '{15, 1'b1, 1'b0};
    tbl[4]  = '{16, 1'b0, 1'b0};
    tbl[5]  = '{30, 1'b0, 1'b0};
    tbl[6]  = '{31, 1'b0, 1'b1};
    tbl[7]  = '{32, 1'b0, 1'b1};
    tbl[8]  = '{33, 1'b1, 1'b1};
    tbl[9]  = '{46, 1'b1, 1'b1};
    tbl[10] = '{47, 1'b0, 1'b1};
    tbl[11] = '{48, 1'b0, 1'b1};
    tbl[12] = '{62, 1'b0, 1'b1};
    tbl[13] = '{63, 1'b0, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst[d]    = 1'b1;
      drv_v[d]  = 1'b0;
      drv_p[d]  = '0;
      n[d]      = 0;
      hv[d]     = 1'b0;
      hp[d]     = '0;
      cur[d]    = '0;
      exp_uf[d] = 1'b0;
      acc[d]    = 1'b0;
    end

    repeat (3) cycle();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // First falling toggle four clks after release.
    seen_hi = 0;
    fall_at = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (o_bclk[0]) seen_hi = 1;
      else if (seen_hi != 0 && fall_at < 0) fall_at = i;
    end
    chk("first_fall_clk", 0, fall_at, 4);

    ufc = 0;
    for (int i = 0; i < 512; i++) begin
      cycle();
      if (o_uf[0]) ufc++;
    end
    chk("idle_uf_count", 0, ufc, 2);

    // Known pattern loaded before the first frame.
    rst[0] = 1'b1;
    repeat (2) cycle();
    rst[0]   = 1'b0;
    drv_v[0] = 1'b1;
    drv_p[0] = {16'h8001, 16'h7FFE};
    cycle();
    drv_v[0] = 1'b0;
    for (int i = 0; i < 260; i++) begin
      cycle();
      if (n[0] % 4 == 0 && n[0] >= 4 && n[0] <= 256) begin
        for (int e = 0; e < 14; e++) begin
          if (bidx(0) == tbl[e].b) begin
            chk("tbl_sdata", 0, int'(o_sd[0]),
                int'(tbl[e].sd));
            chk("tbl_lrclk", 0, int'(o_lr[0]),
                int'(tbl[e].lr));
          end
        end
      end
    end

    // Continuous stream of incrementing pairs.
    for (int i = 0; i < 300 && (n[0] % 256) != 100; i++)
      cycle();
    chk("align_stream", 0, n[0] % 256, 100);
    k        = 1;
    drv_v[0] = 1'b1;
    drv_p[0] = {sample_t'(k), sample_t'(~k)};
    ufc      = 0;
    rises    = 0;
    drops    = 0;
    prev     = o_rdy[0];
    for (int i = 0; i < 1280; i++) begin
      cycle();
      if (o_uf[0]) ufc++;
      if (o_rdy[0] && !prev) rises++;
      if (!o_rdy[0] && prev) drops++;
      prev = o_rdy[0];
      if (acc[0]) begin
        k++;
        drv_p[0] = {sample_t'(k), sample_t'(~k)};
      end
    end
    drv_v[0] = 1'b0;
    chk("stream_uf", 0, ufc, 0);
    chk("stream_ready_rises", 0, rises, 5);
    chk("stream_ready_drops", 0, drops, 6);

    // Valid lands in the frame-start clk, holding empty.
    for (int i = 0; i < 600 && hv[0]; i++) cycle();
    for (int i = 0; i < 300 && ((n[0] + 1) % 256) != 4; i++)
      cycle();
    drv_v[0] = 1'b1;
    drv_p[0] = rand_pair();
    cycle();
    drv_v[0] = 1'b0;
    chk("simul_uf", 0, int'(o_uf[0]), 1);
    chk("simul_ready", 0, int'(o_rdy[0]), 0);
    repeat (256) cycle();
    chk("simul_next_uf", 0, int'(o_uf[0]), 0);
    chk("simul_next_ready", 0, int'(o_rdy[0]), 1);

    // Reset at b = 40 with a pair held.
    drv_v[0] = 1'b1;
    drv_p[0] = rand_pair();
    cycle();
    drv_v[0] = 1'b0;
    for (int i = 0; i < 300 &&
         !(bidx(0) == 40 && n[0] % 4 == 2); i++)
      cycle();
    chk("rst_pre_held", 0, int'(o_rdy[0]), 0);
    chk("rst_pre_bclk", 0, int'(o_bclk[0]), 1);
    rst[0] = 1'b1;
    cycle();
    chk("rst_bclk", 0, int'(o_bclk[0]), 0);
    chk("rst_lrclk", 0, int'(o_lr[0]), 0);
    chk("rst_sdata", 0, int'(o_sd[0]), 0);
    chk("rst_ready", 0, int'(o_rdy[0]), 1);
    chk("rst_uf", 0, int'(o_uf[0]), 0);
    rst[0] = 1'b0;
    repeat (4) cycle();
    chk("post_rst_uf", 0, int'(o_uf[0]), 1);

    // Fast link: bclk every clk, lrclk high for 17 bits.
    prev = o_bclk[1];
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("b_bclk_toggle", 1, int'(o_bclk[1]),
          int'(!prev));
      prev = o_bclk[1];
    end
    for (int i = 0; i < 200 && o_lr[1]; i++) cycle();
    for (int i = 0; i < 200 && !o_lr[1]; i++) cycle();
    len = 0;
    for (int i = 0; i < 200 && o_lr[1]; i++) begin
      len++;
      cycle();
    end
    chk("b_lr_high_len", 1, len, 34);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
